// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and default phase geometry.
package cpu_pkg;

    localparam int CPU_NUM_PHASES = 12;
    localparam int CPU_PHASE_W    = 4;
    localparam int CPU_MIN_LEN    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/phase_len_clamp.sv
// Combinational clamp of an instruction phase count into [CPU_MIN_LEN, NUM_PHASES].
module phase_len_clamp
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES = CPU_NUM_PHASES,
    parameter int CNT_W      = CPU_PHASE_W
) (
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] len_clamped
);

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(CPU_MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(NUM_PHASES);

    always_comb begin
        if (len < MIN_LEN) begin
            len_clamped = MIN_LEN;
        end else if (len > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end else begin
            len_clamped = len;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// One-hot instruction phase sequencer with variable length, stall and retired count.
// Optional single-step HALT state is enabled by defining PHASE_SEQ_STEP_EN.
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES = CPU_NUM_PHASES,
    parameter int CNT_W      = CPU_PHASE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  stall,
    input  logic [CNT_W-1:0]      len,
`ifdef PHASE_SEQ_STEP_EN
    input  logic                  step_mode,
    input  logic                  step_req,
`endif
    output logic [NUM_PHASES-1:0] phase,
    output logic [CNT_W-1:0]      phase_idx,
    output logic                  busy,
    output logic                  instr_done,
    output logic [31:0]           instr_count
);

    localparam logic [CNT_W-1:0]      FULL_END    = CNT_W'(NUM_PHASES);
    localparam logic [NUM_PHASES-1:0] FIRST_PHASE = NUM_PHASES'(1);

    seq_state_t       state;
    logic [CNT_W-1:0] end_len;
    logic [CNT_W-1:0] len_clamped;
    logic             is_final;
    logic             halt_on_exit;

    phase_len_clamp #(
        .NUM_PHASES (NUM_PHASES),
        .CNT_W      (CNT_W)
    ) u_clamp (
        .len         (len),
        .len_clamped (len_clamped)
    );

    assign is_final   = (state == RUN) && (phase_idx == end_len - CNT_W'(1));
    assign instr_done = is_final && !stall;

`ifdef PHASE_SEQ_STEP_EN
    assign halt_on_exit = step_mode;
`else
    assign halt_on_exit = 1'b0;
`endif

    // end_len holds the full length until decode's count is sampled leaving idx 1
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase_idx   <= '0;
            end_len     <= FULL_END;
            phase       <= '0;
            busy        <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state     <= RUN;
                        phase_idx <= '0;
                        end_len   <= FULL_END;
                        phase     <= FIRST_PHASE;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (is_final) begin
                            instr_count <= instr_count + 32'd1;
                            phase_idx   <= '0;
                            end_len     <= FULL_END;
                            if (halt_on_exit) begin
                                state <= HALT;
                                phase <= '0;
                                busy  <= 1'b1;
                            end else if (run) begin
                                phase <= FIRST_PHASE;
                            end else begin
                                state <= IDLE;
                                phase <= '0;
                                busy  <= 1'b0;
                            end
                        end else begin
                            phase_idx <= phase_idx + CNT_W'(1);
                            phase     <= {phase[NUM_PHASES-2:0], 1'b0};
                            if (phase_idx == CNT_W'(1)) begin
                                end_len <= len_clamped;
                            end
                        end
                    end
                end
`ifdef PHASE_SEQ_STEP_EN
                HALT: begin
                    if (step_req) begin
                        phase_idx <= '0;
                        end_len   <= FULL_END;
                        if (run) begin
                            state <= RUN;
                            phase <= FIRST_PHASE;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            phase <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    phase_idx <= '0;
                    end_len   <= FULL_END;
                    phase     <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised successor to the fixed 12-phase `cpu_clock` generator. It emits a one-hot phase vector that drives fetch, decode, selector, alu and register-load strobes. Each instruction sequence ends early at a per-instruction phase count supplied by decode, instead of always running all 12 phases. It also adds a stall hold, a retired-instruction counter and an optional single-step mode, and sits at the top of the CPU beside `fetch`/`decode`.

## Interface
Parameters:
- `NUM_PHASES`, 12: maximum phases per instruction, at least 3.
- `CNT_W`, 4: width of phase index and length fields; must satisfy 2^CNT_W > NUM_PHASES.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `run`  in  1  permits starting a new instruction sequence.
- `stall`  in  1  freezes the current phase.
- `len`  in  CNT_W  phase count of the current instruction, from decode (`num_of_ope`-derived).
- `phase`  out  NUM_PHASES  one-hot active phase; all zeros when idle.
- `phase_idx`  out  CNT_W  0-based index of active phase.
- `busy`  out  1  high while a sequence is in progress.
- `instr_done`  out  1  high during the final phase's non-stalled cycle.
- `instr_count`  out  32  count of completed instructions.
- `step_mode`, `step_req`  in  1 each  present only with `PHASE_SEQ_STEP_EN`.

## Operation
States:
- IDLE: `phase`=0, `busy`=0.
- RUN: one phase bit set.
- HALT: step mode only; `phase`=0, `busy`=1.

IDLE:
- `run`=1 at an edge moves to RUN with `phase_idx`=0.

RUN:
- Each edge with `stall`=0 advances `phase_idx` by 1.
- `stall`=1 holds `phase_idx`, `phase` and the latched length.

Length latching:
- `len` is sampled at the edge that leaves `phase_idx`=1 (decode phase) with `stall`=0.
- The value is clamped to [3, NUM_PHASES]: 0–2 becomes 3, and values above NUM_PHASES become NUM_PHASES.
- Until the sample is taken, the effective end is NUM_PHASES.

Final phase:
- The final phase is `phase_idx` = end−1.
- `instr_done` = final phase AND `stall`=0. It is combinational from state and `stall`.
- At the edge leaving the final phase: `instr_count` increments by 1, wrapping 0xFFFFFFFF→0.
- Next state after the final phase is RUN at idx 0 if `run`=1, otherwise IDLE.

Rules:
- `run` is ignored mid-sequence; deasserting it never truncates an instruction.
- `reset` overrides everything, including `stall`.
- Reset mid-sequence aborts the instruction without incrementing `instr_count`.

## Timing
- Reset values: `phase`=0, `phase_idx`=0, `busy`=0, `instr_done`=0, `instr_count`=0, state IDLE, latched end = NUM_PHASES.
- `run` high in IDLE at edge N puts `phase[0]`=1 in the cycle after edge N.
- An instruction of length L with no stalls occupies exactly L cycles.
- Back-to-back instructions have no idle cycle between the final phase and the next idx 0.
- Each stall cycle adds exactly one cycle.
- `instr_count` is updated one edge after `instr_done` is seen high.

## Configuration
`PHASE_SEQ_STEP_EN`, when defined:
- Adds the `step_mode` and `step_req` ports.
- With `step_mode`=1, the final-phase exit goes to HALT instead of RUN or IDLE.
- HALT leaves on a `step_req`=1 edge, to RUN idx 0 if `run`=1, otherwise IDLE.
- `step_req` outside HALT is ignored.

When undefined:
- The ports are absent, HALT is not synthesised, and behaviour is as if `step_mode`=0.

## Structure
Shared package `cpu_pkg`:
- State enum (IDLE, RUN, HALT).
- Default constants `CPU_NUM_PHASES`=12 and `CPU_PHASE_W`=4.
- `CPU_MIN_LEN`=3.

Sub-module `phase_len_clamp`:
- Combinational clamp of `len` to [CPU_MIN_LEN, NUM_PHASES].
- Reused by decode for range checks.

Everything else (FSM, index counter, one-hot decode, instruction counter) lives in `phase_sequencer`.

## Test plan
- Reset, then `run`=1, `len`=12, no stall: `phase` walks bit 0..11 in 12 cycles, `instr_done` is high on idx 11 only, `instr_count`=1, and idx 0 recurs immediately.
- `len`=5, `run` dropped during idx 2: the sequence completes at idx 4, then IDLE with `phase`=0 and `busy`=0, `instr_count`=1.
- `len`=1 and `len`=15 with NUM_PHASES=12: sequences run 3 and 12 cycles respectively.
- `stall` held 3 cycles at idx 4 of an 8-phase instruction: the instruction takes 11 cycles, `phase` is frozen at bit 4, and `instr_done` is low while stalled on the final phase.
- `reset` asserted at idx 6 with `stall`=1: the next cycle is IDLE, `instr_count` is unchanged, and all outputs are at reset values.
- With `PHASE_SEQ_STEP_EN`, `step_mode`=1, `len`=4: the sequencer parks in HALT after idx 3 with `phase`=0 and `busy`=1, and `step_req` pulses resume at idx 0. Also preload `instr_count`=0xFFFFFFFF by force and confirm it wraps to 0.
